// File: rtl/xfer_sched_if.sv
// Handshake bundle between the scheduler, the byte deserializer, the byte queue and the consumer.
// The master modport is the scheduler's view; slave is the environment's view.
interface xfer_sched_if #(
  parameter int LEN_W  = 4,
  parameter int DROP_W = 8
);
  logic              des_ready_in;
  logic              des_ack_out;
  logic [LEN_W-1:0]  q_len_in;
  logic              q_enq_out;
  logic              q_deq_out;
  logic              pop_req_in;
  logic              pop_vld_out;
  logic              full_out;
  logic              empty_out;
  logic [DROP_W-1:0] drop_cnt_out;
  logic              tmo_err_out;

  modport master (
    input  des_ready_in, q_len_in, pop_req_in,
    output des_ack_out, q_enq_out, q_deq_out, pop_vld_out,
           full_out, empty_out, drop_cnt_out, tmo_err_out
  );

  modport slave (
    output des_ready_in, q_len_in, pop_req_in,
    input  des_ack_out, q_enq_out, q_deq_out, pop_vld_out,
           full_out, empty_out, drop_cnt_out, tmo_err_out
  );
endinterface

// File: rtl/xfer_sched.sv
// Deserializer-to-queue scheduler: enqueue FSM with ack handshake, pop serialisation,
// round-robin arbitration with a one-cycle lockout after every queue pulse.
module xfer_sched #(
  parameter int DEPTH        = 8,
  parameter int LEN_W        = 4,
  parameter int DROP_W       = 8,
  parameter int ACK_TMO      = 16,
  parameter int DROP_ON_FULL = 0
) (
  input  logic         clk,
  input  logic         reset,
  xfer_sched_if.master bus
);
  localparam int TMO_W = (ACK_TMO > 2) ? $clog2(ACK_TMO) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

  typedef enum logic [1:0] {IDLE, ENQ, ACK} state_t;

  state_t            st;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [DROP_W-1:0] drop_cnt;
  logic              enq_p, deq_p, pop_vld, ack, tmo_err;
  logic              pop_pend, rr, need_low;
  logic              lock, full, enq_ok, deq_ok, grant_enq, grant_deq, drop_go;

  // q_len_in is stale while a pulse is in flight, so nothing is granted in that cycle.
  always_comb begin
    lock      = enq_p | deq_p;
    full      = (bus.q_len_in == DEPTH_L);
    enq_ok    = (st == IDLE) & bus.des_ready_in & ~need_low & (bus.q_len_in < DEPTH_L) & ~lock;
    deq_ok    = (bus.pop_req_in | pop_pend) & (bus.q_len_in != '0) & ~lock;
    grant_enq = enq_ok & (~deq_ok | ~rr);
    grant_deq = deq_ok & (~enq_ok | rr);
    drop_go   = (DROP_ON_FULL != 0) & (st == IDLE) & bus.des_ready_in & ~need_low & full & ~lock;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      tmo_cnt  <= '0;
      drop_cnt <= '0;
      enq_p    <= 1'b0;
      deq_p    <= 1'b0;
      pop_vld  <= 1'b0;
      ack      <= 1'b0;
      tmo_err  <= 1'b0;
      pop_pend <= 1'b0;
      rr       <= 1'b0;
      need_low <= 1'b0;
    end else begin
      enq_p   <= grant_enq;
      deq_p   <= grant_deq;
      pop_vld <= deq_p;
      if (enq_ok && deq_ok) rr <= ~rr;
      if (grant_deq)             pop_pend <= 1'b0;
      else if (bus.pop_req_in)   pop_pend <= 1'b1;
      if (!bus.des_ready_in) need_low <= 1'b0;
      case (st)
        IDLE: begin
          if (grant_enq) begin
            st <= ENQ;
          end else if (drop_go) begin
            st      <= ACK;
            ack     <= 1'b1;
            tmo_cnt <= '0;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
          end
        end
        ENQ: begin
          st      <= ACK;
          ack     <= 1'b1;
          tmo_cnt <= '0;
        end
        ACK: begin
          if (!bus.des_ready_in) begin
            st  <= IDLE;
            ack <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            // Abandon the handshake; the stuck-high ready must go low before it counts again.
            st       <= IDLE;
            ack      <= 1'b0;
            tmo_err  <= 1'b1;
            need_low <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.des_ack_out  = ack;
  assign bus.q_enq_out    = enq_p;
  assign bus.q_deq_out    = deq_p;
  assign bus.pop_vld_out  = pop_vld;
  assign bus.full_out     = full;
  assign bus.empty_out    = (bus.q_len_in == '0);
  assign bus.drop_cnt_out = drop_cnt;
  assign bus.tmo_err_out  = tmo_err;
endmodule
